// File: rtl/cp0_ctrl_pkg.sv
// rtl/cp0_ctrl_pkg.sv - CP0 register numbers, exception codes and register field masks
//
// Purpose: shared constants for the coprocessor-0 controller.
//   - CP0 register addresses used by mfc0/mtc0.
//   - ExcCode values reported in Cause[6:2].
//   - Field masks and a helper that forces word alignment on PC values.
// Ports: none (package).
package cp0_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bits of SR that actually exist: IM[15:10], EXL[1], IE[0].
  localparam logic [31:0] SR_MASK = 32'h0000_fc03;

  // Clear the byte offset so EPC always holds a word address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - coprocessor-0 exception/interrupt controller beside the M stage
//
// Purpose: holds SR, Cause, EPC and PRId; serves mfc0/mtc0; raises request_int
// to flush the pipeline and redirect fetch to the handler; captures the victim
// PC into EPC and exposes the eret target.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   we, addr, wdata     mtc0 write from M (addr also selects the mfc0 read)
//   rdata               mfc0 read data (combinational, pre-write value)
//   vpc, bd_in          PC of the M-stage instruction and its delay-slot flag
//   exc_code_in         synchronous exception code from M, 0 = none
//   hw_int              level-sensitive external interrupt lines
//   eret                eret in M, clears EXL
//   request_int         combinational flush/redirect request
//   epc_out             eret target, with bypass of a same-cycle mtc0 EPC
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h2022_0701,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        request_int,
  output logic [31:0] epc_out
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:2] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;

  // HANDLER_ADDR is documentation for the fetch unit; victim[1:0] is masked off.
  logic unused_ok;
  assign unused_ok = ^{HANDLER_ADDR, victim[1:0]};

  assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b00};
  assign epc_word   = {epc, 2'b00};

  // Request/priority: EXL masks both sources so handlers are never nested.
  always_comb begin
    int_req     = 1'b0;
    exc_req     = 1'b0;
    request_int = 1'b0;
    victim      = vpc;
    int_req     = sr_ie & ~sr_exl & (|(hw_int & sr_im));
    exc_req     = (exc_code_in != EXC_INT) & ~sr_exl;
    request_int = int_req | exc_req;
    // A delay-slot victim restarts at its branch.
    victim      = bd_in ? (vpc - 32'd4) : vpc;
  end

  always_comb begin
    rdata = 32'b0;
    case (addr)
      CP0_SR:    rdata = sr_word;
      CP0_CAUSE: rdata = cause_word;
      CP0_EPC:   rdata = epc_word;
      CP0_PRID:  rdata = PRID_VALUE;
      default:   rdata = 32'b0;
    endcase
  end

  // Bypass lets "mtc0 EPC; eret" back to back see the new target.
  assign epc_out = (we && addr == CP0_EPC) ? word_align(wdata) : epc_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hw_int;
      if (request_int) begin
        // The victim must not commit, so its mtc0 is dropped here.
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= int_req ? EXC_INT : exc_code_in;
        epc       <= victim[31:2];
      end else begin
        if (we && addr == CP0_SR) begin
          sr_im  <= wdata[15:10];
          sr_exl <= wdata[1];
          sr_ie  <= wdata[0];
        end
        if (we && addr == CP0_EPC) begin
          epc <= wdata[31:2];
        end
        // Placed after the SR write so eret clears EXL even when SR is written.
        if (eret) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline.
- Sits beside the M stage and is the source end of the fetch unit's interrupt redirect: it raises request_int, which steers fetch to 0x4180, and drives epc_out, the eret return target.
- Holds SR, Cause, EPC and PRId.
- Serves mfc0/mtc0 and records the victim PC of the faulting or interrupted instruction.

Parameters:
- PRID_VALUE, 32'h2022_0701, read-only PRId contents.
- HANDLER_ADDR, 32'h0000_4180, documented handler entry; informational only, not used in logic.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- we  in  1  mtc0 write enable (M stage)
- addr  in  5  CP0 register number for mfc0/mtc0
- wdata  in  32  mtc0 write data
- rdata  out  32  mfc0 read data, combinational
- vpc  in  32  PC of the instruction currently in M
- bd_in  in  1  M-stage instruction sits in a branch delay slot
- exc_code_in  in  5  synchronous exception code from M; 0 = none
- hw_int  in  6  external interrupt lines, level-sensitive
- eret  in  1  eret in M
- request_int  out  1  flush pipeline and redirect fetch to handler
- epc_out  out  32  eret target

Behaviour:
- Register map (addresses fixed in paras.v):
  - SR = 12: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause = 13: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC = 14: full 32 bits, bits [1:0] always 0.
  - PRId = 15: PRID_VALUE.
- Reset (synchronous): SR = 0, Cause = 0, EPC = 0. request_int reads 0 in the cycle after reset.
- int_req = SR.IE & ~SR.EXL & |(hw_int & SR.IM), combinational.
- exc_req = (exc_code_in != 0) & ~SR.EXL.
- request_int = int_req | exc_req, combinational, same cycle as the causing condition.
- On a clock edge with request_int = 1:
  - EXL <= 1.
  - Cause.BD <= bd_in.
  - ExcCode <= 0 if int_req, else exc_code_in. Interrupt wins when both are pending.
  - EPC <= bd_in ? (vpc - 4) & ~3 : vpc & ~3.
  - The same-cycle mtc0 is discarded; the faulting instruction must not commit.
- Cause.IP <= hw_int every cycle, unconditionally, including during a request.
- mtc0 (we = 1, no request):
  - SR and EPC write their defined bits; EPC[1:0] is forced to 0.
  - Cause and PRId writes are ignored.
  - Writes to undefined addresses have no effect.
- eret: EXL <= 0 at the edge.
  - If mtc0 to SR occurs in the same cycle, the written IM/IE take effect but EXL is cleared regardless.
  - eret with EXL already 0 is legal; EXL stays 0.
- epc_out = (we & addr == 14) ? {wdata[31:2], 2'b00} : EPC. This bypass covers an mtc0 EPC immediately followed by eret.
- rdata = selected register contents; undefined addresses read 0. A read of a register being written in the same cycle returns the old value.
- Nested requests are blocked while EXL = 1, for both interrupts and exceptions.
- The handler itself is responsible for clearing exceptions taken with EXL = 1.
- hw_int glitches shorter than one cycle are invisible (sampled only at the edge for IP; combinational for the request).

Decomposition:
- paras.v: CP0 address constants CP0_SR, CP0_CAUSE, CP0_EPC, CP0_PRID; ExcCode constants EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
- Single module; no sub-module is warranted.
- The request/priority logic stays inline as a small always_comb-style block.

Test Plan:
1. Reset, then mtc0 SR = 32'h0000_0401; assert hw_int = 6'b000001 with vpc = 0x3010, bd_in = 0 -> request_int = 1 same cycle; next cycle EPC = 0x3010, ExcCode = 0, EXL = 1, request_int = 0 with hw_int still high.
2. exc_code_in = 12 (Ov), vpc = 0x3024, bd_in = 1, EXL = 0 -> request_int = 1; EPC = 0x3020, Cause.BD = 1, Cause[6:2] = 12.
3. Interrupt and exc_code_in = 10 in the same cycle -> ExcCode = 0 (interrupt priority); a same-cycle mtc0 EPC = 0x5000 is discarded, and EPC = vpc.
4. mtc0 EPC = 0x3401 with eret in the same cycle -> epc_out = 0x3400 combinationally; next cycle EPC = 0x3400, EXL = 0.
5. With EXL = 1, exc_code_in = 4 and hw_int unmasked -> request_int stays 0; EPC and Cause are unchanged except IP, which tracks hw_int.
6. mfc0 on addresses 15, 13, 20 -> PRID_VALUE, current Cause, 0; an mtc0 to addr 15 leaves PRId unchanged.
